rename_stage: RTL and testbench



---
 rtl/rename_stage.sv | 150 +++++++++++++++
 tb/tb_rename_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rename_stage.sv
// Register-rename stage: maps rs1/rs2/rd through an arch-to-phys table, allocates
// destinations from a circular free list, and registers the renamed instruction.
module rename_stage #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned PW        = $clog2(NUM_PREGS),
  parameter int unsigned CTRL_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [8:0]        i_pc,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [4:0]        i_rd,
  input  logic              i_regwrite,
  input  logic [31:0]       i_imm,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [8:0]        o_pc,
  output logic [31:0]       o_imm,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_regwrite,
  output logic [PW-1:0]     o_prs1,
  output logic [PW-1:0]     o_prs2,
  output logic [PW-1:0]     o_prd,
  output logic [PW-1:0]     o_old_prd,
  input  logic              free_valid,
  input  logic [PW-1:0]     free_preg
);

  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned DEPTH     = NUM_PREGS - NUM_AREGS;
  localparam int unsigned FAW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]     map_q [NUM_AREGS];
  logic [PW-1:0]     fl_q  [DEPTH];
  logic [FAW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]     count_q, count_d;

  logic              valid_q, valid_d;
  logic [8:0]        pc_q, pc_d;
  logic [31:0]       imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              regwrite_q, regwrite_d;
  logic [PW-1:0]     prs1_q, prs1_d, prs2_q, prs2_d, prd_q, prd_d, old_prd_q, old_prd_d;

  logic alloc_needed, fl_empty, fl_full, accept, pop, push;

  function automatic logic [FAW-1:0] ptr_inc(input logic [FAW-1:0] p);
    return (p == FAW'(DEPTH - 1)) ? '0 : p + FAW'(1);
  endfunction

  // Handshake and free-list pointer/count next state
  always_comb begin
    alloc_needed = i_regwrite && (i_rd != 5'd0);
    fl_empty     = (count_q == '0);
    fl_full      = (count_q == PW'(DEPTH));
    o_ready      = reset && (!valid_q || i_ready) && (!alloc_needed || !fl_empty);
    accept       = i_valid && o_ready;
    pop          = accept && alloc_needed;
    push         = free_valid && (free_preg != '0) && !fl_full;
    head_d       = pop  ? ptr_inc(head_q) : head_q;
    tail_d       = push ? ptr_inc(tail_q) : tail_q;
    count_d      = count_q;
    if (pop && !push)      count_d = count_q - PW'(1);
    else if (push && !pop) count_d = count_q + PW'(1);
  end

  // Output stage: load on accept, drain when consumed, otherwise hold
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    ctrl_d     = ctrl_q;
    regwrite_d = regwrite_q;
    prs1_d     = prs1_q;
    prs2_d     = prs2_q;
    prd_d      = prd_q;
    old_prd_d  = old_prd_q;
    if (accept) begin
      valid_d    = 1'b1;
      pc_d       = i_pc;
      imm_d      = i_imm;
      ctrl_d     = i_ctrl;
      regwrite_d = i_regwrite;
      prs1_d     = map_q[i_rs1];
      prs2_d     = map_q[i_rs2];
      prd_d      = alloc_needed ? fl_q[head_q] : '0;
      old_prd_d  = alloc_needed ? map_q[i_rd]  : '0;
    end else if (i_ready) begin
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AREGS; i++) map_q[i] <= PW'(i);
      for (int i = 0; i < DEPTH; i++)     fl_q[i]  <= PW'(NUM_AREGS + i);
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= PW'(DEPTH);
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      ctrl_q     <= '0;
      regwrite_q <= 1'b0;
      prs1_q     <= '0;
      prs2_q     <= '0;
      prd_q      <= '0;
      old_prd_q  <= '0;
    end else begin
      // Entry 0 is never written: pop requires a nonzero rd
      if (pop)  map_q[i_rd]  <= fl_q[head_q];
      if (push) fl_q[tail_q] <= free_preg;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      ctrl_q     <= ctrl_d;
      regwrite_q <= regwrite_d;
      prs1_q     <= prs1_d;
      prs2_q     <= prs2_d;
      prd_q      <= prd_d;
      old_prd_q  <= old_prd_d;
    end
  end

  // Returning p0 or overfilling the list is a commit-side bug
  always_ff @(posedge clk) begin
    if (reset && free_valid) begin
      assert ((free_preg != '0) && !fl_full)
        else $error("rename_stage: illegal free push of p%0d", free_preg);
    end
  end

  assign o_valid    = valid_q;
  assign o_pc       = pc_q;
  assign o_imm      = imm_q;
  assign o_ctrl     = ctrl_q;
  assign o_regwrite = regwrite_q;
  assign o_prs1     = prs1_q;
  assign o_prs2     = prs2_q;
  assign o_prd      = prd_q;
  assign o_old_prd  = old_prd_q;

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: vector table for the basic stream plus
// hand sequences for free-list exhaustion, pop/push wrap and mid-stream reset.
module tb_rename_stage;

  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned PW        = 6;
  localparam int unsigned CTRL_W    = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid, o_ready, i_regwrite, o_valid, i_ready, o_regwrite;
  logic [8:0]        i_pc, o_pc;
  logic [4:0]        i_rs1, i_rs2, i_rd;
  logic [31:0]       i_imm, o_imm;
  logic [CTRL_W-1:0] i_ctrl, o_ctrl;
  logic [PW-1:0]     o_prs1, o_prs2, o_prd, o_old_prd, free_preg;
  logic              free_valid;

  int n_tests = 0;
  int n_fail  = 0;

  rename_stage #(.NUM_PREGS(NUM_PREGS), .PW(PW), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_regwrite(i_regwrite), .i_imm(i_imm), .i_ctrl(i_ctrl),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_imm(o_imm),
    .o_ctrl(o_ctrl), .o_regwrite(o_regwrite), .o_prs1(o_prs1), .o_prs2(o_prs2),
    .o_prd(o_prd), .o_old_prd(o_old_prd), .free_valid(free_valid), .free_preg(free_preg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, rdy;
    logic       er, ev;
    logic [5:0] p1, p2, pd, po;
  } vec_t;

  function automatic vec_t mk(input int v, input int rs1, input int rs2, input int rd,
                              input int rw, input int rdy, input int er, input int ev,
                              input int p1, input int p2, input int pd, input int po);
    vec_t t;
    t.v = 1'(v);   t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
    t.rw = 1'(rw); t.rdy = 1'(rdy); t.er = 1'(er);   t.ev = 1'(ev);
    t.p1 = 6'(p1); t.p2 = 6'(p2);   t.pd = 6'(pd);   t.po = 6'(po);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                       input logic rw, input logic rdy, input logic fv, input int fp,
                       input int tag);
    i_valid = v; i_rs1 = 5'(rs1); i_rs2 = 5'(rs2); i_rd = 5'(rd);
    i_regwrite = rw; i_ready = rdy; free_valid = fv; free_preg = 6'(fp);
    i_pc = 9'(tag); i_imm = 32'hA000_0000 + 32'(tag); i_ctrl = 10'(tag * 3);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t       tbl [13];
  int         exp_tag;
  int         q [$];
  int         pv, exp_p;

  initial begin
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    reset = 1'b0;
    #1;
    check("reset_o_ready", 32'(o_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_valid", 32'(o_valid), 0);
    check("reset_o_prd", 32'(o_prd), 0);
    check("reset_o_pc", 32'(o_pc), 0);
    reset = 1'b1;

    tbl[0]  = mk(1, 5, 0, 5, 1, 1, 1, 1, 5, 0, 32, 5);
    tbl[1]  = mk(1, 5, 5, 6, 1, 1, 1, 1, 32, 32, 33, 6);
    tbl[2]  = mk(1, 6, 1, 0, 1, 1, 1, 1, 33, 1, 0, 0);
    tbl[3]  = mk(1, 3, 0, 3, 0, 1, 1, 1, 3, 0, 0, 0);
    tbl[4]  = mk(1, 3, 6, 3, 1, 1, 1, 1, 3, 33, 34, 3);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 5, 3, 5, 1, 1, 1, 1, 32, 34, 35, 32);
    for (int i = 7; i < 12; i++) tbl[i] = mk(1, 8, 0, 8, 1, 0, 0, 1, 32, 34, 35, 32);
    tbl[12] = mk(1, 8, 0, 8, 1, 1, 1, 1, 8, 0, 36, 8);

    exp_tag = 0;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].rdy, 1'b0, 0, i + 1);
      #1;
      check($sformatf("v%0d_o_ready", i), 32'(o_ready), 32'(tbl[i].er));
      if (tbl[i].v && tbl[i].er) exp_tag = i + 1;
      step();
      check($sformatf("v%0d_o_valid", i), 32'(o_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        check($sformatf("v%0d_prs1", i), 32'(o_prs1), 32'(tbl[i].p1));
        check($sformatf("v%0d_prs2", i), 32'(o_prs2), 32'(tbl[i].p2));
        check($sformatf("v%0d_prd", i), 32'(o_prd), 32'(tbl[i].pd));
        check($sformatf("v%0d_old_prd", i), 32'(o_old_prd), 32'(tbl[i].po));
        check($sformatf("v%0d_pc", i), 32'(o_pc), 32'(exp_tag));
        check($sformatf("v%0d_imm", i), o_imm, 32'hA000_0000 + 32'(exp_tag));
        check($sformatf("v%0d_ctrl", i), 32'(o_ctrl), 32'(10'(exp_tag * 3)));
      end
    end

    // Drain the remaining 27 free registers (37..63)
    for (int k = 0; k < 27; k++) begin
      drive(1'b1, 0, 0, (k % 31) + 1, 1'b1, 1'b1, 1'b0, 0, 100 + k);
      #1;
      check("drain_o_ready", 32'(o_ready), 1);
      step();
      check("drain_prd", 32'(o_prd), 32'(37 + k));
    end
    drive(1'b1, 0, 0, 9, 1'b1, 1'b1, 1'b0, 0, 200);
    #1;
    check("empty_writer_o_ready", 32'(o_ready), 0);
    step();
    check("empty_no_accept_o_valid", 32'(o_valid), 0);
    drive(1'b1, 0, 0, 4, 1'b0, 1'b1, 1'b0, 0, 201);
    #1;
    check("empty_nonwriter_o_ready", 32'(o_ready), 1);
    step();
    check("empty_nonwriter_o_valid", 32'(o_valid), 1);
    check("empty_nonwriter_prd", 32'(o_prd), 0);
    check("empty_nonwriter_regwrite", 32'(o_regwrite), 0);
    drive(1'b1, 0, 0, 9, 1'b1, 1'b1, 1'b1, 40, 202);
    #1;
    check("push_cycle_o_ready", 32'(o_ready), 0);
    step();
    drive(1'b1, 0, 0, 9, 1'b1, 1'b1, 1'b0, 0, 203);
    #1;
    check("after_push_o_ready", 32'(o_ready), 1);
    step();
    check("after_push_prd", 32'(o_prd), 40);
    check("after_push_pc", 32'(o_pc), 32'(9'(203)));

    // Refill three entries, then steady pop+push across pointer wrap
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 50 + k, 0);
      q.push_back(50 + k);
      step();
    end
    for (int k = 0; k < 100; k++) begin
      pv = 1 + (k * 7) % 63;
      drive(1'b1, 0, 0, (k % 31) + 1, 1'b1, 1'b1, 1'b1, pv, k);
      #1;
      check("wrap_o_ready", 32'(o_ready), 1);
      exp_p = q.pop_front();
      q.push_back(pv);
      step();
      check("wrap_prd", 32'(o_prd), 32'(exp_p));
    end

    // Asynchronous reset with a valid instruction held in the output stage
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    check("pre_reset_o_valid", 32'(o_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_o_valid", 32'(o_valid), 0);
    check("midreset_o_prd", 32'(o_prd), 0);
    check("midreset_o_old_prd", 32'(o_old_prd), 0);
    check("midreset_o_prs1", 32'(o_prs1), 0);
    check("midreset_o_imm", o_imm, 0);
    check("midreset_o_ctrl", 32'(o_ctrl), 0);
    check("midreset_o_regwrite", 32'(o_regwrite), 0);
    check("midreset_o_ready", 32'(o_ready), 0);
    step();
    reset = 1'b1;
    drive(1'b1, 7, 5, 7, 1'b1, 1'b1, 1'b0, 0, 77);
    #1;
    check("postreset_o_ready", 32'(o_ready), 1);
    step();
    check("postreset_o_valid", 32'(o_valid), 1);
    check("postreset_prd", 32'(o_prd), 32);
    check("postreset_old_prd", 32'(o_old_prd), 7);
    check("postreset_prs1", 32'(o_prs1), 7);
    check("postreset_prs2", 32'(o_prs2), 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
